jam_cost_server: RTL and testbench
==================================

JAM_COST_SERVER -- requirements
Module: jam_cost_server

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter: TIMEOUT_CYCLES, default 50000, SERVE-state cycle limit before timeout (range 2..65535).
REQ-003 CLK  input  1  clock, all state updates on rising edge.
REQ-004 RST  input  1  asynchronous active-high reset.
REQ-005 load_valid  input  1  cost-table load beat present.
REQ-006 load_ready  output  1  block accepts a load beat this cycle.
REQ-007 load_data  input  7  cost value; beats in raster order (W0J0, W0J1 .. W7J7).
REQ-008 W  input  3  worker index from solver.
REQ-009 J  input  3  job index from solver.
REQ-010 Cost  output  7  cost[W][J], registered.
REQ-011 Valid  input  1  solver result-valid.
REQ-012 MinCost  input  10  solver minimum cost.
REQ-013 MatchCount  input  4  solver count of minimum-cost assignments.
REQ-014 res_min  output  10  captured MinCost.
REQ-015 res_cnt  output  4  captured MatchCount.
REQ-016 done  output  1  result captured or timed out.
REQ-017 timeout  output  1  TIMEOUT_CYCLES elapsed without Valid.

Function
REQ-018 States SHALL be LOAD, SERVE, DONE; reset enters LOAD.
REQ-019 LOAD: load_ready=1; beat accepted when load_valid&&load_ready; writes mem[idx], 6-bit idx increments.
REQ-020 Accepting the 64th beat (idx=63) SHALL transition to SERVE on the same edge; load_ready=0 from then on.
REQ-021 SERVE: every cycle Cost <= mem[{W,J}]; one-cycle latency, W/J changes each cycle supported.
REQ-022 Cost SHALL be 0 in LOAD; hold last value in DONE.
REQ-023 SERVE: 16-bit cycle counter starts at 0 on entry, increments each SERVE cycle.
REQ-024 Valid=1 in SERVE SHALL capture MinCost/MatchCount into res_min/res_cnt, set done, go DONE next edge.
REQ-025 Counter reaching TIMEOUT_CYCLES-1 without Valid SHALL set timeout=1, done=1, go DONE.
REQ-026 Valid and timeout condition in same cycle: Valid wins; timeout stays 0.
REQ-027 Valid in LOAD and DONE, and load_valid outside LOAD, SHALL be ignored.
REQ-028 DONE SHALL be exited only by reset; res_*, done, timeout hold.

Reset
REQ-029 RST SHALL immediately force: state LOAD, idx 0, counter 0, Cost 0, res_min 0, res_cnt 0, done 0, timeout 0, load_ready 1 after release; mem contents undefined, not reset.
REQ-030 Reset mid-LOAD or mid-SERVE SHALL discard progress; next load restarts at index 0.

Configuration
REQ-031 Macro JAM_SRV_CHECK_EN defined: adds inputs exp_min (10), exp_cnt (4), outputs pass (1), fail (1), all reset 0.
REQ-032 With macro, on Valid capture pass=1 iff MinCost==exp_min && MatchCount==exp_cnt, else fail=1; timeout sets fail=1; held in DONE.
REQ-033 Without macro these ports and logic SHALL be absent; other behaviour identical.

Verification
REQ-034 Load mem[k]=k (k=0..63) back-to-back; W=3,J=5 -> Cost=29 next cycle; W=7,J=7 -> 63.
REQ-035 load_valid high every other cycle -> SERVE entered only after 64th accepted beat (cycle ~128), load_ready=0 after.
REQ-036 In SERVE, Valid=1 with MinCost=100, MatchCount=2 -> res_min=100, res_cnt=2, done=1; later Valid with other values ignored.
REQ-037 TIMEOUT_CYCLES=16, no Valid -> timeout=1, done=1 after 16th SERVE cycle; Valid on that same cycle -> timeout=0, result captured.
REQ-038 JAM_SRV_CHECK_EN, exp_min=100, exp_cnt=2; MinCost=100, MatchCount=3 -> fail=1, pass=0; MatchCount=2 -> pass=1.
REQ-039 RST pulse after 10 load beats -> all outputs reset; 64 further beats needed to reach SERVE.

Source files
------------

// File: rtl/jam_cost_server_if.sv
// Bus bundle for jam_cost_server: cost-table load stream, solver lookup port and result capture.
// The JAM_SRV_CHECK_EN macro adds the expected-result inputs and the pass/fail flags.
interface jam_cost_server_if;
    logic       load_valid;
    logic       load_ready;
    logic [6:0] load_data;
    logic [2:0] W;
    logic [2:0] J;
    logic [6:0] Cost;
    logic       Valid;
    logic [9:0] MinCost;
    logic [3:0] MatchCount;
    logic [9:0] res_min;
    logic [3:0] res_cnt;
    logic       done;
    logic       timeout;
`ifdef JAM_SRV_CHECK_EN
    logic [9:0] exp_min;
    logic [3:0] exp_cnt;
    logic       pass;
    logic       fail;

    modport master (
        output load_valid, load_data, W, J, Valid, MinCost, MatchCount, exp_min, exp_cnt,
        input  load_ready, Cost, res_min, res_cnt, done, timeout, pass, fail
    );
    modport slave (
        input  load_valid, load_data, W, J, Valid, MinCost, MatchCount, exp_min, exp_cnt,
        output load_ready, Cost, res_min, res_cnt, done, timeout, pass, fail
    );
`else
    modport master (
        output load_valid, load_data, W, J, Valid, MinCost, MatchCount,
        input  load_ready, Cost, res_min, res_cnt, done, timeout
    );
    modport slave (
        input  load_valid, load_data, W, J, Valid, MinCost, MatchCount,
        output load_ready, Cost, res_min, res_cnt, done, timeout
    );
`endif
endinterface

// File: rtl/jam_cost_server.sv
// Holds an 8x8 job-assignment cost table, serves registered lookups to a solver and captures its result.
// Optional JAM_SRV_CHECK_EN compares the captured result against expected values (pass/fail flags).
module jam_cost_server #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic            CLK,
    input  logic            RST,
    jam_cost_server_if.slave bus
);
    typedef enum logic [1:0] {LOAD, SERVE, DONE} state_t;

    localparam logic [15:0] LAST_CYC = 16'(TIMEOUT_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [5:0] idx;
    logic [15:0] cyc_cnt;
    logic [6:0] mem [64];
    logic [6:0] cost_q;
    logic [9:0] res_min_q;
    logic [3:0] res_cnt_q;
    logic       done_q;
    logic       timeout_q;
    logic       load_ready_c;
    logic       load_fire;
    logic       capture;
    logic       expire;
`ifdef JAM_SRV_CHECK_EN
    logic       pass_q;
    logic       fail_q;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= LOAD;
        else     state <= state_nxt;
    end

    // Valid outranks the timeout when both land on the final SERVE cycle.
    always_comb begin
        state_nxt    = state;
        load_ready_c = 1'b0;
        load_fire    = 1'b0;
        capture      = 1'b0;
        expire       = 1'b0;
        case (state)
            LOAD: begin
                load_ready_c = 1'b1;
                load_fire    = bus.load_valid;
                if (load_fire && (idx == 6'd63)) state_nxt = SERVE;
            end
            SERVE: begin
                capture = bus.Valid;
                expire  = !bus.Valid && (cyc_cnt == LAST_CYC);
                if (capture || expire) state_nxt = DONE;
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = LOAD;
        endcase
    end

    // Table storage carries no reset; a fresh load always rewrites every entry.
    always_ff @(posedge CLK) begin
        if (load_fire) mem[idx] <= bus.load_data;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx       <= '0;
            cyc_cnt   <= '0;
            cost_q    <= '0;
            res_min_q <= '0;
            res_cnt_q <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
`ifdef JAM_SRV_CHECK_EN
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
`endif
        end else begin
            case (state)
                LOAD: begin
                    cost_q  <= '0;
                    cyc_cnt <= '0;
                    if (load_fire) idx <= idx + 6'd1;
                end
                SERVE: begin
                    cost_q  <= mem[{bus.W, bus.J}];
                    cyc_cnt <= cyc_cnt + 16'd1;
                    if (capture) begin
                        res_min_q <= bus.MinCost;
                        res_cnt_q <= bus.MatchCount;
                        done_q    <= 1'b1;
`ifdef JAM_SRV_CHECK_EN
                        if ((bus.MinCost == bus.exp_min) && (bus.MatchCount == bus.exp_cnt))
                            pass_q <= 1'b1;
                        else
                            fail_q <= 1'b1;
`endif
                    end
                    if (expire) begin
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
`ifdef JAM_SRV_CHECK_EN
                        fail_q    <= 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.load_ready = load_ready_c;
    assign bus.Cost       = cost_q;
    assign bus.res_min    = res_min_q;
    assign bus.res_cnt    = res_cnt_q;
    assign bus.done       = done_q;
    assign bus.timeout    = timeout_q;
`ifdef JAM_SRV_CHECK_EN
    assign bus.pass       = pass_q;
    assign bus.fail       = fail_q;
`endif
endmodule

// File: tb/tb_jam_cost_server.sv
// Directed-plus-random bench for jam_cost_server against a cycle-level behavioural model.
// Built with JAM_SRV_CHECK_EN defined it also checks the pass/fail flags.
module tb_jam_cost_server;
    localparam int TO = 16;
    localparam int PH_LOAD  = 0;
    localparam int PH_SERVE = 1;
    localparam int PH_DONE  = 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    jam_cost_server_if bus();
    jam_cost_server #(.TIMEOUT_CYCLES(TO)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    logic [6:0] tbl [64];
    int         m_phase;
    int         m_idx;
    int         m_serve;
    logic [6:0] m_cost;
    logic [9:0] m_min;
    logic [3:0] m_rcnt;
    logic       m_done;
    logic       m_to;
    logic       m_pass;
    logic       m_fail;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".cost"},    16'(bus.Cost), 16'(m_cost));
        check({tag, ".ready"},   16'(bus.load_ready), 16'(m_phase == PH_LOAD));
        check({tag, ".res_min"}, 16'(bus.res_min), 16'(m_min));
        check({tag, ".res_cnt"}, 16'(bus.res_cnt), 16'(m_rcnt));
        check({tag, ".done"},    16'(bus.done), 16'(m_done));
        check({tag, ".timeout"}, 16'(bus.timeout), 16'(m_to));
`ifdef JAM_SRV_CHECK_EN
        check({tag, ".pass"},    16'(bus.pass), 16'(m_pass));
        check({tag, ".fail"},    16'(bus.fail), 16'(m_fail));
`endif
    endtask

    task automatic model_reset();
        m_phase = PH_LOAD;
        m_idx   = 0;
        m_serve = 0;
        m_cost  = '0;
        m_min   = '0;
        m_rcnt  = '0;
        m_done  = 1'b0;
        m_to    = 1'b0;
        m_pass  = 1'b0;
        m_fail  = 1'b0;
    endtask

    // One clock: sample inputs as the DUT will see them, then advance the model.
    task automatic step();
        logic       lv = bus.load_valid;
        logic [6:0] ld = bus.load_data;
        logic [2:0] w  = bus.W;
        logic [2:0] j  = bus.J;
        logic       v  = bus.Valid;
        logic [9:0] mc = bus.MinCost;
        logic [3:0] mk = bus.MatchCount;
        logic       match;
`ifdef JAM_SRV_CHECK_EN
        match = (mc == bus.exp_min) && (mk == bus.exp_cnt);
`else
        match = 1'b0;
`endif
        @(posedge CLK);
        #1;
        if (m_phase == PH_LOAD) begin
            m_cost = '0;
            if (lv) begin
                tbl[m_idx] = ld;
                m_idx++;
                if (m_idx == 64) begin
                    m_phase = PH_SERVE;
                    m_serve = 0;
                end
            end
        end else if (m_phase == PH_SERVE) begin
            m_cost = tbl[int'(w) * 8 + int'(j)];
            m_serve++;
            if (v) begin
                m_min   = mc;
                m_rcnt  = mk;
                m_done  = 1'b1;
                m_pass  = match;
                m_fail  = !match;
                m_phase = PH_DONE;
            end else if (m_serve == TO) begin
                m_to    = 1'b1;
                m_done  = 1'b1;
                m_fail  = 1'b1;
                m_phase = PH_DONE;
            end
        end
    endtask

    task automatic idle_inputs();
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.W          = '0;
        bus.J          = '0;
        bus.Valid      = 1'b0;
        bus.MinCost    = '0;
        bus.MatchCount = '0;
    endtask

    task automatic do_reset(input string tag);
        idle_inputs();
        RST = 1'b1;
        #1;
        model_reset();
        check_all({tag, ".in_rst"});
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check_all({tag, ".released"});
    endtask

    // Offer beats until nbeats have been accepted; solver inputs are noise during the load.
    task automatic load(input bit idx_data, input bit gap, input int nbeats, input string tag);
        int acc = 0;
        for (int c = 0; c < 4 * nbeats + 8 && acc < nbeats; c++) begin
            bus.load_valid = gap ? (c % 2 == 0) : 1'b1;
            bus.load_data  = idx_data ? 7'(acc) : 7'($urandom);
            bus.W          = 3'($urandom);
            bus.J          = 3'($urandom);
            bus.Valid      = 1'($urandom_range(0, 1));
            bus.MinCost    = 10'($urandom);
            bus.MatchCount = 4'($urandom);
            if (bus.load_valid) acc++;
            step();
            check_all(tag);
        end
        idle_inputs();
    endtask

    task automatic serve_reads(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            bus.W     = 3'($urandom);
            bus.J     = 3'($urandom);
            bus.Valid = 1'b0;
            step();
            check_all(tag);
        end
    endtask

    task automatic solver_result(input logic [9:0] mc, input logic [3:0] mk);
        bus.W          = 3'($urandom);
        bus.J          = 3'($urandom);
        bus.Valid      = 1'b1;
        bus.MinCost    = mc;
        bus.MatchCount = mk;
        step();
        bus.Valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
`ifdef JAM_SRV_CHECK_EN
        bus.exp_min = 10'd100;
        bus.exp_cnt = 4'd2;
`endif
        model_reset();

        // Identity table, back-to-back beats, fixed lookups, then a captured result.
        do_reset("r1");
        load(1'b1, 1'b0, 64, "load_id");
        check("serve_entered", 16'(bus.load_ready), 16'd0);
        bus.W = 3'd3; bus.J = 3'd5;
        step();
        check("cost_w3j5", 16'(bus.Cost), 16'd29);
        bus.W = 3'd7; bus.J = 3'd7;
        step();
        check("cost_w7j7", 16'(bus.Cost), 16'd63);
        check_all("fixed");
        serve_reads(6, "serve1");
        solver_result(10'd100, 4'd2);
        check("res_min_100", 16'(bus.res_min), 16'd100);
        check("res_cnt_2", 16'(bus.res_cnt), 16'd2);
        check("done_cap", 16'(bus.done), 16'd1);
        check_all("cap1");
        for (int i = 0; i < 3; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 7'($urandom);
            solver_result(10'(55 + i), 4'(7 + i));
            check_all("done_hold");
        end
        idle_inputs();

        // Sparse load, then no Valid until the timeout fires.
        do_reset("r2");
        load(1'b0, 1'b1, 64, "load_gap");
        serve_reads(5, "serve2");
        for (int i = 0; i < 30 && !m_done; i++) begin
            bus.W = 3'($urandom);
            bus.J = 3'($urandom);
            step();
            check_all("to_wait");
        end
        check("timeout_set", 16'(bus.timeout), 16'd1);
        check("timeout_done", 16'(bus.done), 16'd1);

        // Valid on the very cycle the timeout would fire.
        do_reset("r3");
        load(1'b0, 1'b0, 64, "load_rnd");
        serve_reads(TO - 1, "serve3");
        solver_result(10'd100, 4'd3);
        check("race_timeout", 16'(bus.timeout), 16'd0);
        check("race_cnt", 16'(bus.res_cnt), 16'd3);
        check_all("race");

        // Reset mid-load discards progress; a full 64 beats are needed again.
        do_reset("r4");
        load(1'b0, 1'b0, 10, "load_part");
        RST = 1'b1;
        #1;
        model_reset();
        check_all("mid_rst");
        do_reset("r5");
        load(1'b0, 1'b0, 63, "reload63");
        check("ready_after63", 16'(bus.load_ready), 16'd1);
        load(1'b0, 1'b0, 1, "reload64");
        check("ready_after64", 16'(bus.load_ready), 16'd0);
        serve_reads(4, "serve5");
        solver_result(10'd100, 4'd2);
        check_all("cap5");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
